fir_stream_driver: RTL and testbench

Synthesizable initiator for the FIR `input_valid`/`output_valid` handshake. It is the driving side of the FIR's sample-in/sample-out protocol. It streams up to `DEPTH` preloaded input samples into the FIR, one per handshake, and captures each FIR result into an on-chip result memory. This lets the FIR be exercised on the FPGA without the simulation bench. It sits between a host/loader port and the FIR instance.

---
 rtl/fir_stream_driver.sv | 218 +++++++++++++++++++++
 tb/tb_fir_stream_driver.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_driver.sv
// Streams preloaded samples into the FIR over its valid handshake and stores each result.
// Define FIR_DRV_CHECK_EN to add an expected-value memory and a mismatch counter.
module fir_stream_driver #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 38,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 16384,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_samples,
  input  logic                  smp_we,
  input  logic [ADDR_WIDTH-1:0] smp_waddr,
  input  logic [IN_WIDTH-1:0]   smp_wdata,
  input  logic [ADDR_WIDTH-1:0] res_raddr,
  output logic [OUT_WIDTH-1:0]  res_rdata,
  output logic [IN_WIDTH-1:0]   fir_din,
  output logic                  fir_input_valid,
  input  logic [OUT_WIDTH-1:0]  fir_dout,
  input  logic                  fir_output_valid,
`ifdef FIR_DRV_CHECK_EN
  input  logic                  exp_we,
  input  logic [OUT_WIDTH-1:0]  exp_wdata,
  output logic [ADDR_WIDTH:0]   mismatch_cnt,
  output logic [ADDR_WIDTH-1:0] first_mismatch_idx,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH:0]   samples_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [CNT_W-1:0]    TMO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRIVE, S_GAP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   samples_done_q, samples_done_d;
  logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [IN_WIDTH-1:0]   din_q, din_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ov_prev_q;
  logic                  res_we;
  logic                  ov_rise;
  logic                  last_sample;

  logic [IN_WIDTH-1:0]   smp_mem [DEPTH];
  logic [OUT_WIDTH-1:0]  res_mem [DEPTH];
  logic [IN_WIDTH-1:0]   smp_rdata_q;
  logic [OUT_WIDTH-1:0]  res_rdata_q;

  // A level that is already high when DRIVE starts is not a new result.
  assign ov_rise     = fir_output_valid && !ov_prev_q;
  assign last_sample = (({1'b0, idx_q} + CNT_ONE) == count_q);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    count_d        = count_q;
    samples_done_d = samples_done_q;
    tmo_cnt_d      = tmo_cnt_q;
    din_d          = din_q;
    valid_d        = valid_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = err_q;
    res_we         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d          = 1'b0;
          samples_done_d = '0;
          idx_d          = '0;
          if (num_samples == '0) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            count_d = (num_samples > DEPTH_CNT) ? DEPTH_CNT : num_samples;
            busy_d  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        din_d     = smp_rdata_q;
        valid_d   = 1'b1;
        tmo_cnt_d = '0;
        state_d   = S_DRIVE;
      end
      S_DRIVE: begin
        if (ov_rise) begin
          res_we         = 1'b1;
          samples_done_d = samples_done_q + CNT_ONE;
          valid_d        = 1'b0;
          state_d        = S_GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (!fir_output_valid) begin
          if (last_sample) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      count_q        <= '0;
      samples_done_q <= '0;
      tmo_cnt_q      <= '0;
      din_q          <= '0;
      valid_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      ov_prev_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      count_q        <= count_d;
      samples_done_q <= samples_done_d;
      tmo_cnt_q      <= tmo_cnt_d;
      din_q          <= din_d;
      valid_q        <= valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      ov_prev_q      <= fir_output_valid;
    end
  end

  // Addressed by idx_d so the sample is already registered while in FETCH.
  always_ff @(posedge clk) begin
    if (smp_we && !busy_q) smp_mem[smp_waddr] <= smp_wdata;
    smp_rdata_q <= smp_mem[idx_d];
  end

  always_ff @(posedge clk) begin
    if (res_we) res_mem[idx_q] <= fir_dout;
    if (rst) res_rdata_q <= '0;
    else     res_rdata_q <= res_mem[res_raddr];
  end

`ifdef FIR_DRV_CHECK_EN
  logic [OUT_WIDTH-1:0]  exp_mem [DEPTH];
  logic [OUT_WIDTH-1:0]  exp_rdata_q;
  logic [ADDR_WIDTH:0]   mm_cnt_q, mm_cnt_d;
  logic [ADDR_WIDTH-1:0] first_mm_q, first_mm_d;

  always_ff @(posedge clk) begin
    if (exp_we && !busy_q) exp_mem[smp_waddr] <= exp_wdata;
    exp_rdata_q <= exp_mem[idx_d];
  end

  always_comb begin
    mm_cnt_d   = mm_cnt_q;
    first_mm_d = first_mm_q;
    if (state_q == S_IDLE && start) begin
      mm_cnt_d   = '0;
      first_mm_d = '0;
    end else if (res_we && (fir_dout != exp_rdata_q)) begin
      if (mm_cnt_q != '1) mm_cnt_d = mm_cnt_q + CNT_ONE;
      if (mm_cnt_q == '0) first_mm_d = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mm_cnt_q   <= '0;
      first_mm_q <= '0;
    end else begin
      mm_cnt_q   <= mm_cnt_d;
      first_mm_q <= first_mm_d;
    end
  end

  assign mismatch_cnt       = mm_cnt_q;
  assign first_mismatch_idx = first_mm_q;
`endif

  assign res_rdata       = res_rdata_q;
  assign fir_din         = din_q;
  assign fir_input_valid = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign timeout_err     = err_q;
  assign samples_done    = samples_done_q;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver with a behavioural FIR model (latency 5, output = din*3).
module tb_fir_stream_driver;
  localparam int IW    = 16;
  localparam int OW    = 38;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 16;
  localparam int LAT   = 5;

  logic          clk = 1'b0;
  logic          rst, start, smp_we;
  logic [AW:0]   num_samples;
  logic [AW-1:0] smp_waddr, res_raddr;
  logic [IW-1:0] smp_wdata, fir_din;
  logic [OW-1:0] res_rdata, fir_dout;
  logic          fir_input_valid, fir_output_valid, busy, done, timeout_err;
  logic [AW:0]   samples_done;
`ifdef FIR_DRV_CHECK_EN
  logic          exp_we;
  logic [OW-1:0] exp_wdata;
  logic [AW:0]   mismatch_cnt;
  logic [AW-1:0] first_mismatch_idx;
`endif

  fir_stream_driver #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .smp_we(smp_we), .smp_waddr(smp_waddr), .smp_wdata(smp_wdata),
    .res_raddr(res_raddr), .res_rdata(res_rdata),
    .fir_din(fir_din), .fir_input_valid(fir_input_valid),
    .fir_dout(fir_dout), .fir_output_valid(fir_output_valid),
`ifdef FIR_DRV_CHECK_EN
    .exp_we(exp_we), .exp_wdata(exp_wdata),
    .mismatch_cnt(mismatch_cnt), .first_mismatch_idx(first_mismatch_idx),
`endif
    .busy(busy), .done(done), .timeout_err(timeout_err), .samples_done(samples_done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // FIR model: answers LAT cycles after input_valid rises, keeps output_valid
  // high for at least hold_len cycles and until input_valid has dropped.
  bit            mdl_en = 1'b0;
  int            hold_len = 1;
  int            mdl_cd, mdl_age;
  logic          mdl_vprev;
  logic [IW-1:0] mdl_din;

  always @(posedge clk) begin
    if (rst) begin
      fir_output_valid <= 1'b0;
      fir_dout         <= '0;
      mdl_cd           <= 0;
      mdl_age          <= 0;
      mdl_vprev        <= 1'b0;
      mdl_din          <= '0;
    end else begin
      mdl_vprev <= fir_input_valid;
      if (mdl_en && fir_input_valid && !mdl_vprev) begin
        mdl_din <= fir_din;
        mdl_cd  <= LAT - 1;
      end else if (mdl_cd > 1) begin
        mdl_cd <= mdl_cd - 1;
      end else if (mdl_cd == 1) begin
        fir_output_valid <= 1'b1;
        fir_dout         <= OW'(mdl_din) * OW'(3);
        mdl_cd           <= 0;
        mdl_age          <= 1;
      end
      if (fir_output_valid) begin
        if (!fir_input_valid && mdl_age >= hold_len) fir_output_valid <= 1'b0;
        mdl_age <= mdl_age + 1;
      end
    end
  end

  int   done_cnt, vhigh_cnt, hs_viol, ov_rise_cnt, min_gap, low_run;
  bit   seen_fall;
  logic mon_v_prev = 1'b0;
  logic mon_ov_prev = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (fir_input_valid === 1'b1) vhigh_cnt++;
    if (fir_output_valid === 1'b1 && mon_ov_prev !== 1'b1) ov_rise_cnt++;
    if (fir_input_valid === 1'b1 && mon_v_prev !== 1'b1) begin
      if (fir_output_valid === 1'b1) hs_viol++;
      if (seen_fall && low_run < min_gap) min_gap = low_run;
      low_run = 0;
    end
    if (fir_input_valid !== 1'b1) begin
      if (mon_v_prev === 1'b1) seen_fall = 1'b1;
      low_run++;
    end
    mon_v_prev  = fir_input_valid;
    mon_ov_prev = fir_output_valid;
  end

  task automatic clear_mon();
    done_cnt = 0; vhigh_cnt = 0; hs_viol = 0; ov_rise_cnt = 0;
    min_gap = 1000; low_run = 0; seen_fall = 1'b0;
  endtask

  task automatic load(input int addr, input logic [IW-1:0] val, input logic [OW-1:0] expv);
    @(negedge clk);
    smp_we = 1'b1; smp_waddr = AW'(addr); smp_wdata = val;
`ifdef FIR_DRV_CHECK_EN
    exp_we = 1'b1; exp_wdata = expv;
`endif
    @(negedge clk);
    smp_we = 1'b0;
`ifdef FIR_DRV_CHECK_EN
    exp_we = 1'b0;
`endif
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    num_samples = n[AW:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total_cnt++;
    if (!seen) $display("FAIL %s_done_wait: done=%b after 3000 cycles, required 1", tag, done);
    else pass_cnt++;
    @(negedge clk);
    $display("run %s: samples_done=%0d timeout_err=%0b done_pulses=%0d", tag, samples_done, timeout_err, done_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (fir_input_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fir_input_valid); else pass_cnt++;
    total_cnt++; if (fir_din !== '0) $display("FAIL reset_din: got %0h want 0", fir_din); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_err: got %b want 0", timeout_err); else pass_cnt++;
    total_cnt++; if (samples_done !== '0) $display("FAIL reset_samples_done: got %0d want 0", samples_done); else pass_cnt++;
    total_cnt++; if (res_rdata !== '0) $display("FAIL reset_res_rdata: got %0h want 0", res_rdata); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [OW-1:0] exp_res [4] = '{38'd3, 38'd6, 38'd9, 38'd12};
    mdl_en = 1'b1; hold_len = 1;
    for (int i = 0; i < 4; i++) load(i, IW'(i + 1), '0);
    clear_mon();
    start_run(4);
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_fetch: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (fir_input_valid !== 1'b0) $display("FAIL basic_valid_fetch: got %b want 0", fir_input_valid); else pass_cnt++;
    wait_done("basic");
    total_cnt++; if (samples_done !== 5'd4) $display("FAIL basic_samples_done: got %0d want 4", samples_done); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL basic_timeout_err: got %b want 0", timeout_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (min_gap != 3) $display("FAIL basic_gap: got %0d low cycles want 3", min_gap); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); res_raddr = AW'(i);
      @(negedge clk);
      total_cnt++;
      if (res_rdata !== exp_res[i]) $display("FAIL basic_res[%0d]: got %0d want %0d", i, res_rdata, exp_res[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_handshake();
    logic [OW-1:0] exp_res [3] = '{38'd21, 38'd24, 38'd27};
    mdl_en = 1'b1; hold_len = 3;
    for (int i = 0; i < 3; i++) load(i, IW'(i + 7), '0);
    clear_mon();
    start_run(3);
    wait_done("handshake");
    total_cnt++; if (ov_rise_cnt != 3) $display("FAIL hs_results: got %0d want 3", ov_rise_cnt); else pass_cnt++;
    total_cnt++; if (samples_done !== 5'd3) $display("FAIL hs_samples_done: got %0d want 3", samples_done); else pass_cnt++;
    total_cnt++; if (hs_viol != 0) $display("FAIL hs_valid_overlap: got %0d want 0", hs_viol); else pass_cnt++;
    total_cnt++; if (min_gap != 4) $display("FAIL hs_gap: got %0d low cycles want 4", min_gap); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); res_raddr = AW'(i);
      @(negedge clk);
      total_cnt++;
      if (res_rdata !== exp_res[i]) $display("FAIL hs_res[%0d]: got %0d want %0d", i, res_rdata, exp_res[i]);
      else pass_cnt++;
    end
    hold_len = 1;
  endtask

  task automatic test_timeout();
    mdl_en = 1'b0;
    clear_mon();
    start_run(2);
    wait_done("timeout");
    total_cnt++; if (timeout_err !== 1'b1) $display("FAIL tmo_err: got %b want 1", timeout_err); else pass_cnt++;
    total_cnt++; if (samples_done !== '0) $display("FAIL tmo_samples_done: got %0d want 0", samples_done); else pass_cnt++;
    total_cnt++; if (fir_input_valid !== 1'b0) $display("FAIL tmo_valid: got %b want 0", fir_input_valid); else pass_cnt++;
    total_cnt++; if (vhigh_cnt != TMO) $display("FAIL tmo_drive_cycles: got %0d want %0d", vhigh_cnt, TMO); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL tmo_done_pulses: got %0d want 1", done_cnt); else pass_cnt++;
    mdl_en = 1'b1;
  endtask

  task automatic test_zero_count();
    clear_mon();
    start_run(0);
    total_cnt++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++; if (vhigh_cnt != 0) $display("FAIL zero_traffic: got %0d valid cycles want 0", vhigh_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); else pass_cnt++;
    $display("run zero: done_pulses=%0d", done_cnt);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < DEPTH; i++) load(i, IW'(i + 1), '0);
    clear_mon();
    start_run(DEPTH + 5);
    wait_done("saturate");
    total_cnt++; if (samples_done !== 5'd16) $display("FAIL sat_samples_done: got %0d want 16", samples_done); else pass_cnt++;
    total_cnt++; if (ov_rise_cnt != DEPTH) $display("FAIL sat_captures: got %0d want %0d", ov_rise_cnt, DEPTH); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); res_raddr = AW'(i);
      @(negedge clk);
      total_cnt++;
      if (res_rdata !== OW'(3 * (i + 1))) $display("FAIL sat_res[%0d]: got %0d want %0d", i, res_rdata, 3 * (i + 1));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midrun();
    logic [OW-1:0] exp_res [4] = '{38'd15, 38'd18, 38'd21, 38'd24};
    bit hit = 1'b0;
    clear_mon();
    start_run(4);
    for (int i = 0; i < 200; i++) begin
      if (samples_done === 5'd1 && fir_input_valid === 1'b1) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    total_cnt++; if (!hit) $display("FAIL rst_reach_sample2: samples_done=%0d valid=%b, required 1/1", samples_done, fir_input_valid); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (fir_input_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", fir_input_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (samples_done !== '0) $display("FAIL rst_mid_samples_done: got %0d want 0", samples_done); else pass_cnt++;
    total_cnt++; if (fir_din !== '0) $display("FAIL rst_mid_din: got %0h want 0", fir_din); else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) load(i, IW'(i + 5), '0);
    clear_mon();
    start_run(4);
    wait_done("rerun");
    total_cnt++; if (samples_done !== 5'd4) $display("FAIL rerun_samples_done: got %0d want 4", samples_done); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); res_raddr = AW'(i);
      @(negedge clk);
      total_cnt++;
      if (res_rdata !== exp_res[i]) $display("FAIL rerun_res[%0d]: got %0d want %0d", i, res_rdata, exp_res[i]);
      else pass_cnt++;
    end
  endtask

`ifdef FIR_DRV_CHECK_EN
  task automatic test_checker();
    logic [OW-1:0] exp_vals [4] = '{38'd3, 38'd6, 38'd0, 38'd12};
    for (int i = 0; i < 4; i++) load(i, IW'(i + 1), exp_vals[i]);
    clear_mon();
    start_run(4);
    wait_done("checker");
    total_cnt++; if (mismatch_cnt !== 5'd1) $display("FAIL chk_mismatch_cnt: got %0d want 1", mismatch_cnt); else pass_cnt++;
    total_cnt++; if (first_mismatch_idx !== 4'd2) $display("FAIL chk_first_idx: got %0d want 2", first_mismatch_idx); else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0;
    smp_we = 1'b0; smp_waddr = '0; smp_wdata = '0; res_raddr = '0;
`ifdef FIR_DRV_CHECK_EN
    exp_we = 1'b0; exp_wdata = '0;
`endif
    clear_mon();
    test_reset();
    test_basic();
    test_handshake();
    test_timeout();
    test_zero_count();
    test_saturate();
    test_reset_midrun();
`ifdef FIR_DRV_CHECK_EN
    test_checker();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
